// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit.
// Keeps a tag tracker for the post-ID stages. For every source operand it
// picks the youngest matching producer, or the register file when nothing
// matches. Issue stalls while that producer's data is not yet valid.

// Per-source selector: finds the youngest match and checks whether it is ready.
module fwd_hazard_src #(
  parameter int REG_AW    = 5,
  parameter int DATA_W    = 32,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int SEL_W     = $clog2(FWD_DEPTH+1)
) (
  input  logic [REG_AW-1:0]                  i_src,
  input  logic                               i_used,
  input  logic [FWD_DEPTH-1:0]               i_vld,
  input  logic [FWD_DEPTH-1:0]               i_ld,
  input  logic [FWD_DEPTH-1:0][REG_AW-1:0]   i_dst,
  input  logic [DATA_W-1:0]                  i_rf_data,
  input  logic [FWD_DEPTH-1:0][DATA_W-1:0]   i_stage_data,
  output logic [SEL_W-1:0]                   o_sel,
  output logic [DATA_W-1:0]                  o_data,
  output logic                               o_hazard
);
  logic [FWD_DEPTH-1:0] w_match;

  // r0 and unused sources never match, so they always fall back to the RF
  always_comb begin
    w_match = '0;
    for (int k = 0; k < FWD_DEPTH; k++)
      w_match[k] = i_vld[k] & i_used & (i_src != '0) & (i_dst[k] == i_src);
  end

  // Scan from the oldest stage down so the youngest match overrides the rest;
  // an older ready match never hides a younger one that is not ready
  always_comb begin
    o_sel    = '0;
    o_data   = i_rf_data;
    o_hazard = 1'b0;
    for (int k = FWD_DEPTH-1; k >= 0; k--) begin
      if (w_match[k]) begin
        o_sel    = SEL_W'(k+1);
        o_hazard = i_ld[k] && (k < LOAD_LAT);
        o_data   = o_hazard ? i_rf_data : i_stage_data[k];
      end
    end
  end
endmodule

module fwd_hazard_unit #(
  parameter int REG_AW    = 5,
  parameter int DATA_W    = 32,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int SEL_W     = $clog2(FWD_DEPTH+1)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_pipe_en,
  input  logic                          i_flush,
  input  logic                          i_id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]     i_id_src_addr,
  input  logic [NUM_SRC-1:0]            i_id_src_used,
  input  logic [REG_AW-1:0]             i_id_dst_addr,
  input  logic                          i_id_dst_wen,
  input  logic                          i_id_is_load,
  input  logic [NUM_SRC*DATA_W-1:0]     i_rf_data,
  input  logic [FWD_DEPTH*DATA_W-1:0]   i_stage_data,
  output logic                          o_stall,
  output logic [NUM_SRC*SEL_W-1:0]      o_fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0]     o_fwd_data,
  output logic [31:0]                   o_stall_cnt,
  output logic [31:0]                   o_fwd_cnt
);
  // Tracker entry k belongs to the instruction now in post-ID stage k
  logic [FWD_DEPTH-1:0]             r_vld;
  logic [FWD_DEPTH-1:0]             r_ld;
  logic [FWD_DEPTH-1:0][REG_AW-1:0] r_dst;
  logic [31:0]                      r_stall_cnt;
  logic [31:0]                      r_fwd_cnt;

  logic [NUM_SRC-1:0] w_hazard;
  logic               w_issue;
  logic               w_any_fwd;

  genvar i;
  generate
    for (i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_hazard_src #(
        .REG_AW(REG_AW), .DATA_W(DATA_W), .FWD_DEPTH(FWD_DEPTH),
        .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)
      ) u_src (
        .i_src        (i_id_src_addr[i*REG_AW +: REG_AW]),
        .i_used       (i_id_src_used[i]),
        .i_vld        (r_vld),
        .i_ld         (r_ld),
        .i_dst        (r_dst),
        .i_rf_data    (i_rf_data[i*DATA_W +: DATA_W]),
        .i_stage_data (i_stage_data),
        .o_sel        (o_fwd_sel[i*SEL_W +: SEL_W]),
        .o_data       (o_fwd_data[i*DATA_W +: DATA_W]),
        .o_hazard     (w_hazard[i])
      );
    end
  endgenerate

  assign o_stall     = i_id_valid & (|w_hazard);
  assign w_issue     = i_id_valid & ~o_stall & ~i_flush;
  assign w_any_fwd   = |o_fwd_sel;
  assign o_stall_cnt = r_stall_cnt;
  assign o_fwd_cnt   = r_fwd_cnt;

  // Shift tags one stage per advance; a stalled or flushed slot enters as a bubble
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= '0;
      r_ld  <= '0;
      r_dst <= '0;
    end else if (i_pipe_en) begin
      for (int k = FWD_DEPTH-1; k > 0; k--) begin
        r_vld[k] <= r_vld[k-1];
        r_ld[k]  <= r_ld[k-1];
        r_dst[k] <= r_dst[k-1];
      end
      r_vld[0] <= w_issue & i_id_dst_wen;
      r_ld[0]  <= w_issue & i_id_is_load;
      r_dst[0] <= w_issue ? i_id_dst_addr : '0;
    end
  end

  // Saturating stall / forwarded-issue counters, frozen with the pipeline
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else if (i_pipe_en) begin
      if (o_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_issue && w_any_fwd && (r_fwd_cnt != '1))
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: DUT A uses default parameters, DUT B uses
// FWD_DEPTH=4 / LOAD_LAT=2. Both see the same ID stimulus.
module tb_fwd_hazard_unit;
  localparam int AW = 5, DW = 32, NS = 2;
  localparam logic [31:0] RF0 = 32'hF0F0_0000, RF1 = 32'hF1F1_0001;
  localparam logic [31:0] SA0 = 32'h5A00_0000, SA1 = 32'h5A00_0001, SA2 = 32'h5A00_0002;
  localparam logic [31:0] SB0 = 32'hB000_0000, SB1 = 32'hB000_0001;
  localparam logic [31:0] SB2 = 32'hB000_0002, SB3 = 32'hB000_0003;

  logic clk = 1'b0;
  logic rst, pipe_en, flush, id_valid, dst_wen, is_load;
  logic [NS*AW-1:0] src_addr;
  logic [NS-1:0]    src_used;
  logic [AW-1:0]    dst_addr;
  logic [NS*DW-1:0] rf_data;
  logic [3*DW-1:0]  sd_a;
  logic [4*DW-1:0]  sd_b;
  logic             a_stall, b_stall;
  logic [3:0]       a_sel;
  logic [5:0]       b_sel;
  logic [63:0]      a_data, b_data;
  logic [31:0]      a_scnt, a_fcnt, b_scnt, b_fcnt;

  typedef struct packed {
    logic v; logic [4:0] s0; logic [4:0] s1; logic [1:0] u;
    logic [4:0] d; logic w; logic ld; logic pe; logic fl;
  } id_t;
  typedef struct packed {
    logic stall; logic [5:0] sel; logic [63:0] data; logic chk;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0, n_fail = 0;
  int exp_scnt = 0, exp_fcnt = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit u_a (
    .i_clk(clk), .i_rst(rst), .i_pipe_en(pipe_en), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_src_addr(src_addr), .i_id_src_used(src_used),
    .i_id_dst_addr(dst_addr), .i_id_dst_wen(dst_wen), .i_id_is_load(is_load),
    .i_rf_data(rf_data), .i_stage_data(sd_a), .o_stall(a_stall),
    .o_fwd_sel(a_sel), .o_fwd_data(a_data), .o_stall_cnt(a_scnt), .o_fwd_cnt(a_fcnt));

  fwd_hazard_unit #(.FWD_DEPTH(4), .LOAD_LAT(2)) u_b (
    .i_clk(clk), .i_rst(rst), .i_pipe_en(pipe_en), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_src_addr(src_addr), .i_id_src_used(src_used),
    .i_id_dst_addr(dst_addr), .i_id_dst_wen(dst_wen), .i_id_is_load(is_load),
    .i_rf_data(rf_data), .i_stage_data(sd_b), .o_stall(b_stall),
    .o_fwd_sel(b_sel), .o_fwd_data(b_data), .o_stall_cnt(b_scnt), .o_fwd_cnt(b_fcnt));

  task automatic drive(input id_t s);
    id_valid = s.v; src_addr = {s.s1, s.s0}; src_used = s.u;
    dst_addr = s.d; dst_wen = s.w; is_load = s.ld; pipe_en = s.pe; flush = s.fl;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    drive('{1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0});
    repeat (n) tick();
  endtask

  task automatic test_reset;
    exp_t e;
    rst = 1'b1;
    drive('{1'b1, 5'd3, 5'd4, 2'b11, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0});
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{1'b0, 6'h00, {RF1, RF0}, 1'b1});
      #3;
      e = sb.pop_front(); n_tests++;
      if (a_stall !== e.stall || {2'b00, a_sel} !== e.sel || a_data !== e.data) begin
        n_fail++;
        $display("FAIL reset[%0d] stall=%0b sel=%h data=%h want stall=%0b sel=%h data=%h",
                 i, a_stall, a_sel, a_data, e.stall, e.sel, e.data);
      end
      tick();
    end
    n_tests++;
    if ({a_scnt, a_fcnt, b_scnt, b_fcnt} !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_counters got %h %h %h %h want all 0", a_scnt, a_fcnt, b_scnt, b_fcnt);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_alu_chain;
    id_t st[3]; exp_t ex[3]; exp_t e;
    st = '{'{1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0},
           '{1'b1, 5'd3, 5'd1, 2'b11, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0},
           '{1'b1, 5'd4, 5'd3, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0}};
    ex = '{'{1'b0, 6'h00, {RF1, RF0}, 1'b1},
           '{1'b0, 6'h01, {RF1, SA0}, 1'b1},
           '{1'b0, 6'h09, {SA1, SA0}, 1'b1}};
    for (int i = 0; i < 3; i++) begin
      drive(st[i]); sb.push_back(ex[i]); #3;
      e = sb.pop_front(); n_tests++;
      if (a_stall !== e.stall || {2'b00, a_sel} !== e.sel || (e.chk && a_data !== e.data)) begin
        n_fail++;
        $display("FAIL alu_chain[%0d] stall=%0b sel=%h data=%h want stall=%0b sel=%h data=%h",
                 i, a_stall, a_sel, a_data, e.stall, e.sel, e.data);
      end
      tick();
    end
    exp_fcnt += 2;
    n_tests++;
    if (a_fcnt !== exp_fcnt || a_scnt !== exp_scnt) begin
      n_fail++;
      $display("FAIL alu_chain_cnt fwd=%0d stall=%0d want fwd=%0d stall=%0d", a_fcnt, a_scnt, exp_fcnt, exp_scnt);
    end
    idle(4);
  endtask

  task automatic test_load_use;
    id_t st[3]; exp_t ex[3]; exp_t e;
    st = '{'{1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0},
           '{1'b1, 5'd5, 5'd7, 2'b11, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0},
           '{1'b1, 5'd5, 5'd7, 2'b11, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0}};
    ex = '{'{1'b0, 6'h00, {RF1, RF0}, 1'b1},
           '{1'b1, 6'h01, 64'd0,      1'b0},
           '{1'b0, 6'h02, {RF1, SA1}, 1'b1}};
    for (int i = 0; i < 3; i++) begin
      drive(st[i]); sb.push_back(ex[i]); #3;
      e = sb.pop_front(); n_tests++;
      if (a_stall !== e.stall || {2'b00, a_sel} !== e.sel || (e.chk && a_data !== e.data)) begin
        n_fail++;
        $display("FAIL load_use[%0d] stall=%0b sel=%h data=%h want stall=%0b sel=%h data=%h",
                 i, a_stall, a_sel, a_data, e.stall, e.sel, e.data);
      end
      tick();
    end
    exp_scnt += 1; exp_fcnt += 1;
    n_tests++;
    if (a_scnt !== exp_scnt || a_fcnt !== exp_fcnt) begin
      n_fail++;
      $display("FAIL load_use_cnt stall=%0d fwd=%0d want stall=%0d fwd=%0d", a_scnt, a_fcnt, exp_scnt, exp_fcnt);
    end
    idle(4);
  endtask

  task automatic test_double_producer;
    id_t st[6]; exp_t ex[6]; exp_t e;
    st = '{'{1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0},
           '{1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0},
           '{1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0},
           '{1'b1, 5'd4, 5'd9, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0},
           '{1'b1, 5'd9, 5'd4, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0},
           '{1'b1, 5'd9, 5'd4, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0}};
    ex = '{'{1'b0, 6'h00, {RF1, RF0}, 1'b1},
           '{1'b0, 6'h00, {RF1, RF0}, 1'b1},
           '{1'b0, 6'h00, {RF1, RF0}, 1'b1},
           '{1'b0, 6'h09, {SA1, SA0}, 1'b1},   // r4 youngest at stage 0, r9 at stage 1
           '{1'b0, 6'h0B, {SA1, SA2}, 1'b1},   // r9 in last stage still forwards
           '{1'b0, 6'h0C, {SA2, RF0}, 1'b1}};  // r9 dropped, r4 now in last stage
    for (int i = 0; i < 6; i++) begin
      drive(st[i]); sb.push_back(ex[i]); #3;
      e = sb.pop_front(); n_tests++;
      if (a_stall !== e.stall || {2'b00, a_sel} !== e.sel || (e.chk && a_data !== e.data)) begin
        n_fail++;
        $display("FAIL double_prod[%0d] stall=%0b sel=%h data=%h want stall=%0b sel=%h data=%h",
                 i, a_stall, a_sel, a_data, e.stall, e.sel, e.data);
      end
      tick();
    end
    exp_fcnt += 3;
    n_tests++;
    if (a_fcnt !== exp_fcnt) begin
      n_fail++;
      $display("FAIL double_prod_cnt fwd=%0d want %0d", a_fcnt, exp_fcnt);
    end
    idle(4);
  endtask

  task automatic test_r0_unused;
    id_t st[3]; exp_t ex[3]; exp_t e;
    st = '{'{1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0},
           '{1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0},
           '{1'b1, 5'd0, 5'd7, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0}};
    ex = '{'{1'b0, 6'h00, {RF1, RF0}, 1'b1},
           '{1'b0, 6'h00, {RF1, RF0}, 1'b1},
           '{1'b0, 6'h00, {RF1, RF0}, 1'b1}};
    for (int i = 0; i < 3; i++) begin
      drive(st[i]); sb.push_back(ex[i]); #3;
      e = sb.pop_front(); n_tests++;
      if (a_stall !== e.stall || {2'b00, a_sel} !== e.sel || (e.chk && a_data !== e.data)) begin
        n_fail++;
        $display("FAIL r0_unused[%0d] stall=%0b sel=%h data=%h want stall=%0b sel=%h data=%h",
                 i, a_stall, a_sel, a_data, e.stall, e.sel, e.data);
      end
      tick();
    end
    n_tests++;
    if (a_fcnt !== exp_fcnt) begin
      n_fail++;
      $display("FAIL r0_unused_cnt fwd=%0d want %0d", a_fcnt, exp_fcnt);
    end
    idle(4);
  endtask

  task automatic test_freeze_flush;
    id_t st[7]; exp_t ex[7]; exp_t e;
    st = '{'{1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0},
           '{1'b1, 5'd5, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0},
           '{1'b1, 5'd5, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0},
           '{1'b1, 5'd5, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0},
           '{1'b1, 5'd5, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0},
           '{1'b1, 5'd5, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1},
           '{1'b1, 5'd8, 5'd5, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0}};
    ex = '{'{1'b0, 6'h00, {RF1, RF0}, 1'b1},
           '{1'b1, 6'h01, 64'd0,      1'b0},
           '{1'b1, 6'h01, 64'd0,      1'b0},
           '{1'b1, 6'h01, 64'd0,      1'b0},
           '{1'b1, 6'h01, 64'd0,      1'b0},   // tracker held: load still in stage 0
           '{1'b0, 6'h02, {RF1, SA1}, 1'b1},
           '{1'b0, 6'h0C, {SA2, RF0}, 1'b1}};  // flushed r8 never entered
    for (int i = 0; i < 7; i++) begin
      drive(st[i]); sb.push_back(ex[i]); #3;
      e = sb.pop_front(); n_tests++;
      if (a_stall !== e.stall || {2'b00, a_sel} !== e.sel || (e.chk && a_data !== e.data)) begin
        n_fail++;
        $display("FAIL freeze_flush[%0d] stall=%0b sel=%h data=%h want stall=%0b sel=%h data=%h",
                 i, a_stall, a_sel, a_data, e.stall, e.sel, e.data);
      end
      tick();
    end
    exp_scnt += 1; exp_fcnt += 1;
    n_tests++;
    if (a_scnt !== exp_scnt || a_fcnt !== exp_fcnt) begin
      n_fail++;
      $display("FAIL freeze_flush_cnt stall=%0d fwd=%0d want stall=%0d fwd=%0d", a_scnt, a_fcnt, exp_scnt, exp_fcnt);
    end
    idle(4);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int   n;
    drive('{1'b1, 5'd1, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0});
    tick();
    idle(1);
    drive('{1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0});
    sb.push_back('{1'b1, 6'h02, 64'd0, 1'b0});
    #3;
    e = sb.pop_front(); n_tests++;
    if (b_stall !== e.stall || b_sel !== e.sel) begin
      n_fail++;
      $display("FAIL reset_mid_pre stall=%0b sel=%h want stall=%0b sel=%h", b_stall, b_sel, e.stall, e.sel);
    end
    rst = 1'b1;
    sb.push_back('{1'b0, 6'h00, {RF1, RF0}, 1'b1});
    #1;
    e = sb.pop_front(); n_tests++;
    if (b_stall !== e.stall || b_sel !== e.sel || b_data !== e.data) begin
      n_fail++;
      $display("FAIL reset_mid_async stall=%0b sel=%h data=%h want stall=%0b sel=%h data=%h",
               b_stall, b_sel, b_data, e.stall, e.sel, e.data);
    end
    n_tests++;
    if ({b_scnt, b_fcnt, a_scnt, a_fcnt} !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_mid_counters got %h %h %h %h want all 0", b_scnt, b_fcnt, a_scnt, a_fcnt);
    end
    tick();
    rst = 1'b0;
    idle(1);
    drive('{1'b1, 5'd1, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0});
    tick();
    drive('{1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0});
    n = 0;
    for (int i = 0; i < 8; i++) begin
      #3;
      if (b_stall !== 1'b1) break;
      n++;
      tick();
    end
    n_tests++;
    if (n != 2) begin
      n_fail++;
      $display("FAIL reset_mid_penalty cycles=%0d want 2", n);
    end
    sb.push_back('{1'b0, 6'h03, {RF1, SB2}, 1'b1});
    e = sb.pop_front(); n_tests++;
    if (b_stall !== e.stall || b_sel !== e.sel || b_data !== e.data) begin
      n_fail++;
      $display("FAIL reset_mid_fwd stall=%0b sel=%h data=%h want stall=%0b sel=%h data=%h",
               b_stall, b_sel, b_data, e.stall, e.sel, e.data);
    end
    tick();
    n_tests++;
    if (b_scnt !== 32'd2 || b_fcnt !== 32'd1) begin
      n_fail++;
      $display("FAIL reset_mid_cnt stall=%0d fwd=%0d want stall=2 fwd=1", b_scnt, b_fcnt);
    end
    idle(4);
  endtask

  initial begin
    rf_data = {RF1, RF0};
    sd_a    = {SA2, SA1, SA0};
    sd_b    = {SB3, SB2, SB1, SB0};
    test_reset();
    test_alu_chain();
    test_load_use();
    test_double_producer();
    test_r0_unused();
    test_freeze_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
